link_status_monitor: RTL and testbench

//   Per-lane link-state qualifier and indicator driver for the multi-lane PRBS/10G test design.

---
 rtl/link_status_monitor.sv | 181 ++++++++++++++++++
 tb/tb_link_status_monitor.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/link_status_monitor.sv
// Per-lane link_up synchroniser, debounce FSM and saturating drop counter,
// plus a tri-level link LED (off / blink / solid) and a free-running heartbeat LED.
module link_status_monitor #(
  parameter int unsigned NUMBER_OF_LANES   = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = 1024,
  parameter int unsigned CNT_WIDTH         = 16,
  parameter int unsigned BLINK_HALF_PERIOD = 50000000
) (
  input  logic                                 sys_clk_i,
  input  logic                                 sys_rst_n_i,
  input  logic [NUMBER_OF_LANES-1:0]           link_up_i,
  input  logic                                 clr_cnt_i,
  output logic [NUMBER_OF_LANES-1:0]           lane_up_o,
  output logic                                 all_up_o,
  output logic                                 any_up_o,
  output logic [NUMBER_OF_LANES*CNT_WIDTH-1:0] drop_cnt_o,
  output logic                                 led_link_o,
  output logic                                 led_heartbeat_o
);

  localparam int unsigned DcntW  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned BlinkW = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;

  // The edge that leaves DOWN/UP already counts as the first stable cycle, so the
  // qualifying states terminate one count early; total qualification is D stable samples.
  localparam logic [DcntW-1:0]  DcntLast  = DcntW'(DEBOUNCE_CYCLES - 2);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    StDown,
    StQualUp,
    StUp,
    StQualDn
  } lane_state_e;

  logic [NUMBER_OF_LANES-1:0] r_sync1;
  logic [NUMBER_OF_LANES-1:0] r_sync2;

  lane_state_e                r_state   [NUMBER_OF_LANES];
  lane_state_e                w_state_d [NUMBER_OF_LANES];
  logic [DcntW-1:0]           r_dcnt    [NUMBER_OF_LANES];
  logic [DcntW-1:0]           w_dcnt_d  [NUMBER_OF_LANES];
  logic [NUMBER_OF_LANES-1:0] w_drop;
  logic [CNT_WIDTH-1:0]       r_drop_cnt [NUMBER_OF_LANES];

  logic [BlinkW-1:0]          r_blink_cnt;
  logic                       w_blink_wrap;
  logic                       r_phase;
  logic                       w_phase_d;
  logic                       r_led_link;
  logic                       w_led_link_d;

  // Two-flop synchroniser
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= link_up_i;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce FSM next-state
  always_comb begin
    for (int i = 0; i < NUMBER_OF_LANES; i++) begin
      w_state_d[i] = r_state[i];
      w_dcnt_d[i]  = r_dcnt[i];
      w_drop[i]    = 1'b0;
      unique case (r_state[i])
        StDown: begin
          if (r_sync2[i]) begin
            w_state_d[i] = StQualUp;
            w_dcnt_d[i]  = '0;
          end
        end
        StQualUp: begin
          if (!r_sync2[i]) begin
            w_state_d[i] = StDown;
          end else if (r_dcnt[i] == DcntLast) begin
            w_state_d[i] = StUp;
          end else begin
            w_dcnt_d[i] = r_dcnt[i] + DcntW'(1);
          end
        end
        StUp: begin
          if (!r_sync2[i]) begin
            w_state_d[i] = StQualDn;
            w_dcnt_d[i]  = '0;
          end
        end
        StQualDn: begin
          if (r_sync2[i]) begin
            w_state_d[i] = StUp;
          end else if (r_dcnt[i] == DcntLast) begin
            w_state_d[i] = StDown;
            w_drop[i]    = 1'b1;
          end else begin
            w_dcnt_d[i] = r_dcnt[i] + DcntW'(1);
          end
        end
        default: begin
          w_state_d[i] = StDown;
          w_dcnt_d[i]  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      for (int i = 0; i < NUMBER_OF_LANES; i++) begin
        r_state[i] <= StDown;
        r_dcnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUMBER_OF_LANES; i++) begin
        r_state[i] <= w_state_d[i];
        r_dcnt[i]  <= w_dcnt_d[i];
      end
    end
  end

  // Clear has priority over a same-cycle drop; counters stick at all-ones.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      for (int i = 0; i < NUMBER_OF_LANES; i++) begin
        r_drop_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUMBER_OF_LANES; i++) begin
        if (clr_cnt_i) begin
          r_drop_cnt[i] <= '0;
        end else if (w_drop[i] && (r_drop_cnt[i] != {CNT_WIDTH{1'b1}})) begin
          r_drop_cnt[i] <= r_drop_cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    lane_up_o  = '0;
    drop_cnt_o = '0;
    for (int i = 0; i < NUMBER_OF_LANES; i++) begin
      lane_up_o[i] = (r_state[i] == StUp) || (r_state[i] == StQualDn);
      drop_cnt_o[i*CNT_WIDTH +: CNT_WIDTH] = r_drop_cnt[i];
    end
  end

  assign all_up_o = &lane_up_o;
  assign any_up_o = |lane_up_o;

  assign w_blink_wrap = (r_blink_cnt == BlinkLast);
  assign w_phase_d    = r_phase ^ w_blink_wrap;

  // Using the next phase keeps the blinking link LED aligned with the heartbeat.
  always_comb begin
    w_led_link_d = 1'b0;
    if (all_up_o) begin
      w_led_link_d = 1'b1;
    end else if (any_up_o) begin
      w_led_link_d = w_phase_d;
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_led_link  <= 1'b0;
    end else begin
      r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + BlinkW'(1);
      r_phase     <= w_phase_d;
      r_led_link  <= w_led_link_d;
    end
  end

  assign led_link_o      = r_led_link;
  assign led_heartbeat_o = r_phase;

endmodule

// File: tb/tb_link_status_monitor.sv
// Directed bench for link_status_monitor: a run-length lane model checked every cycle,
// plus literal checkpoints on latency, pulse rejection, saturation and clear.
module tb_link_status_monitor;

  localparam int N = 2;
  localparam int D = 8;
  localparam int W = 2;
  localparam int H = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   link = 2'b11;
  logic           clr = 1'b0;
  logic [N-1:0]   lane_up;
  logic           all_up;
  logic           any_up;
  logic [N*W-1:0] drop_cnt;
  logic           led_link;
  logic           led_hb;

  int n_vec = 0;
  int n_err = 0;

  link_status_monitor #(
    .NUMBER_OF_LANES  (N),
    .DEBOUNCE_CYCLES  (D),
    .CNT_WIDTH        (W),
    .BLINK_HALF_PERIOD(H)
  ) dut (
    .sys_clk_i      (clk),
    .sys_rst_n_i    (rst_n),
    .link_up_i      (link),
    .clr_cnt_i      (clr),
    .lane_up_o      (lane_up),
    .all_up_o       (all_up),
    .any_up_o       (any_up),
    .drop_cnt_o     (drop_cnt),
    .led_link_o     (led_link),
    .led_heartbeat_o(led_hb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: a lane flips once it has seen D consecutive synchronised samples
  // disagreeing with its qualified level; heartbeat phase follows the edge count.
  logic [N-1:0] m_s1, m_s2;
  bit           m_q    [N];
  int           m_run  [N];
  int           m_drop [N];
  int           m_n;
  bit           m_phase;
  bit           m_led;

  always @(posedge clk or negedge rst_n) begin : model
    int n_next;
    bit ph;
    bit p_all;
    bit p_any;
    if (!rst_n) begin
      m_s1    <= '0;
      m_s2    <= '0;
      m_n     <= 0;
      m_phase <= 1'b0;
      m_led   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        m_q[i]    <= 1'b0;
        m_run[i]  <= 0;
        m_drop[i] <= 0;
      end
    end else begin
      n_next  = m_n + 1;
      ph      = ((n_next / H) % 2) == 1;
      p_all   = m_q[0] && m_q[1];
      p_any   = m_q[0] || m_q[1];
      m_n     <= n_next;
      m_phase <= ph;
      m_led   <= p_all ? 1'b1 : (p_any ? ph : 1'b0);
      for (int i = 0; i < N; i++) begin
        if (m_s2[i] != m_q[i]) begin
          if (m_run[i] + 1 == D) begin
            m_q[i]   <= !m_q[i];
            m_run[i] <= 0;
            if (m_q[i] && m_drop[i] < (1 << W) - 1 && !clr) m_drop[i] <= m_drop[i] + 1;
            else if (clr) m_drop[i] <= 0;
          end else begin
            m_run[i] <= m_run[i] + 1;
            if (clr) m_drop[i] <= 0;
          end
        end else begin
          m_run[i] <= 0;
          if (clr) m_drop[i] <= 0;
        end
      end
      m_s1 <= link;
      m_s2 <= m_s1;
    end
  end

  always @(negedge clk) begin
    logic [N-1:0]   e_lane;
    logic [N*W-1:0] e_cnt;
    e_lane = {m_q[1], m_q[0]};
    e_cnt  = {W'(m_drop[1]), W'(m_drop[0])};
    chk("model lane_up", 32'(lane_up), 32'(e_lane));
    chk("model all_up", 32'(all_up), 32'(&e_lane));
    chk("model any_up", 32'(any_up), 32'(|e_lane));
    chk("model drop_cnt", 32'(drop_cnt), 32'(e_cnt));
    chk("model led_link", 32'(led_link), 32'(m_led));
    chk("model led_heartbeat", 32'(led_hb), 32'(m_phase));
  end

  // Wait n active edges, then settle 2 time units past the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [N-1:0] l);
    rst_n = 1'b0;
    link  = l;
    edges(2);
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: reset held with both lanes up, then D+2 edges to qualify
    edges(3);
    chk("rst lane_up", 32'(lane_up), 32'h0);
    chk("rst led_link", 32'(led_link), 32'h0);
    rst_n = 1'b1;
    edges(9);
    chk("t1 lane_up edge9", 32'(lane_up), 32'h0);
    edges(1);
    chk("t1 lane_up edge10", 32'(lane_up), 32'h3);
    chk("t1 all_up edge10", 32'(all_up), 32'h1);
    chk("t1 led_link edge10", 32'(led_link), 32'h0);
    edges(1);
    chk("t1 led_link edge11", 32'(led_link), 32'h1);

    // 2: lane0 only -> blinking LED in phase with heartbeat
    do_reset(2'b01);
    edges(10);
    chk("t2 lane_up", 32'(lane_up), 32'h1);
    chk("t2 any_up", 32'(any_up), 32'h1);
    chk("t2 all_up", 32'(all_up), 32'h0);
    edges(2);
    chk("t2 led_link edge12", 32'(led_link), 32'h1);
    chk("t2 heartbeat edge12", 32'(led_hb), 32'h1);
    edges(4);
    chk("t2 led_link edge16", 32'(led_link), 32'h0);
    chk("t2 heartbeat edge16", 32'(led_hb), 32'h0);

    // 3: 5-cycle pulse on lane1 is rejected
    link = 2'b11;
    edges(5);
    link = 2'b01;
    edges(15);
    chk("t3 lane_up", 32'(lane_up), 32'h1);
    chk("t3 drop_cnt", 32'(drop_cnt), 32'h0);

    // 4: 5-cycle dropout on lane0 is rejected
    link = 2'b00;
    edges(5);
    link = 2'b01;
    edges(15);
    chk("t4 lane_up", 32'(lane_up), 32'h1);
    chk("t4 drop_cnt", 32'(drop_cnt), 32'h0);

    // 4b: 20-cycle dropout is a qualified drop
    link = 2'b00;
    edges(9);
    chk("t4b lane_up edge9", 32'(lane_up), 32'h1);
    edges(1);
    chk("t4b lane_up edge10", 32'(lane_up), 32'h0);
    chk("t4b drop_cnt", 32'(drop_cnt), 32'h1);
    edges(10);
    link = 2'b01;
    edges(10);
    chk("t4b relink", 32'(lane_up), 32'h1);

    // 5: four more drops saturate at 3, then clear collides with a sixth drop
    for (int k = 0; k < 4; k++) begin
      link = 2'b00;
      edges(10);
      link = 2'b01;
      edges(10);
    end
    chk("t5 saturated", 32'(drop_cnt), 32'h3);
    link = 2'b00;
    edges(9);
    clr = 1'b1;
    edges(1);
    clr = 1'b0;
    chk("t5 clear wins", 32'(drop_cnt), 32'h0);
    chk("t5 lane down", 32'(lane_up), 32'h0);
    link = 2'b01;
    edges(10);
    link = 2'b00;
    edges(10);
    chk("t5 count after clear", 32'(drop_cnt), 32'h1);

    // 6: reset while lane0 is mid-qualification (dcnt=5 after 8 edges)
    link = 2'b01;
    edges(8);
    rst_n = 1'b0;
    #1;
    chk("t6 lane_up in reset", 32'(lane_up), 32'h0);
    chk("t6 heartbeat in reset", 32'(led_hb), 32'h0);
    chk("t6 drop_cnt in reset", 32'(drop_cnt), 32'h0);
    edges(1);
    rst_n = 1'b1;
    edges(9);
    chk("t6 lane_up edge9", 32'(lane_up), 32'h0);
    edges(1);
    chk("t6 lane_up edge10", 32'(lane_up), 32'h1);

    edges(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
